// File: rtl/mc14500b_icu_param.sv
// ---------------------------------------------------------------------------
// mc14500b_icu_param
//
// Purpose:
//   Parametrised 1-bit industrial control unit modelled on the MC14500B, with
//   a built-in program memory. A program is loaded serially while
//   program_write is high. Otherwise the unit executes one instruction per
//   clock. Each instruction acts on NUM_IN input channels and NUM_OUT
//   registered output channels. Compared with the classic part, it adds a
//   JMP/RTN return stack, sticky stack-error flags and a program-full flag.
//
// Instruction word: cmd = {opcode[3:0], addr[ADDR_W-1:0]}
//
// Ports:
//   clk           in   1         clock; all state changes on the rising edge
//   rst_n         in   1         asynchronous active-low reset
//   program_write in   1         1 = load mode (execution halted)
//   program_cmd   in   CMD_W     word written to program memory in load mode
//   data_in       in   NUM_IN    input channels
//   data_out      out  NUM_OUT   registered output channels
//   opcode        out  4         opcode executing this cycle (NOP0 when idle)
//   pc            out  PC_W      program counter
//   rr            out  1         result register
//   write         out  1         STO/STOC executing with OEN=1 to a real output
//   flag_0        out  1         NOP0 executing
//   flag_f        out  1         NOPF executing
//   flag_jmp      out  1         JMP executing
//   flag_rtn      out  1         RTN executing
//   prog_full     out  1         PROG_DEPTH words have been loaded
//   stack_ovf     out  1         sticky: a JMP found the return stack full
//   stack_unf     out  1         sticky: an RTN found the return stack empty
//
// Handshake: there is no valid/ready pair. program_write is a level-sensitive
//   mode select. Every edge with program_write=1 is one load beat, which is
//   accepted when prog_full=0 and dropped silently when prog_full=1.
// ---------------------------------------------------------------------------
module mc14500b_icu_param #(
    parameter int  ADDR_W      = 8,
    parameter int  PROG_DEPTH  = 256,
    parameter int  NUM_IN      = 8,
    parameter int  NUM_OUT     = 8,
    parameter int  STACK_DEPTH = 4,
    localparam int CMD_W       = 4 + ADDR_W,
    localparam int PC_W        = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               program_write,
    input  logic [CMD_W-1:0]   program_cmd,
    input  logic [NUM_IN-1:0]  data_in,
    output logic [NUM_OUT-1:0] data_out,
    output logic [3:0]         opcode,
    output logic [PC_W-1:0]    pc,
    output logic               rr,
    output logic               write,
    output logic               flag_0,
    output logic               flag_f,
    output logic               flag_jmp,
    output logic               flag_rtn,
    output logic               prog_full,
    output logic               stack_ovf,
    output logic               stack_unf
);

    // The write pointer must be able to hold PROG_DEPTH itself, which marks "full".
    localparam int WP_W = $clog2(PROG_DEPTH + 1);
    // With STACK_DEPTH=0 a one-entry array is still declared to keep it legal.
    // That entry is never written because the stack always reads as full.
    localparam int SD_ALLOC = (STACK_DEPTH > 0) ? STACK_DEPTH : 1;
    localparam int SP_W     = (STACK_DEPTH > 0) ? $clog2(STACK_DEPTH + 1) : 1;
    localparam int unsigned DEPTH_U = PROG_DEPTH;

    typedef enum logic [3:0] {
        OP_NOP0 = 4'h0,
        OP_LD   = 4'h1,
        OP_LDC  = 4'h2,
        OP_AND  = 4'h3,
        OP_ANDC = 4'h4,
        OP_OR   = 4'h5,
        OP_ORC  = 4'h6,
        OP_XNOR = 4'h7,
        OP_STO  = 4'h8,
        OP_STOC = 4'h9,
        OP_IEN  = 4'hA,
        OP_OEN  = 4'hB,
        OP_JMP  = 4'hC,
        OP_RTN  = 4'hD,
        OP_SKZ  = 4'hE,
        OP_NOPF = 4'hF
    } instruction_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [CMD_W-1:0]   mem_q [PROG_DEPTH];
    logic [PC_W-1:0]    stack_q [SD_ALLOC];

    logic [WP_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [SP_W-1:0]    sp_q, sp_d;
    logic               rr_q, rr_d;
    logic               ien_q, ien_d;
    logic               oen_q, oen_d;
    logic [NUM_OUT-1:0] data_out_q, data_out_d;
    logic               stack_ovf_q, stack_ovf_d;
    logic               stack_unf_q, stack_unf_d;

    // -----------------------------------------------------------------------
    // Decode of the current instruction
    // -----------------------------------------------------------------------
    logic [CMD_W-1:0]   instr;
    instruction_t       op;
    logic [ADDR_W-1:0]  addr;
    logic               d_bit;
    logic               out_ok;
    logic               full_w;
    logic               stack_full;
    logic               stack_empty;
    logic [SP_W-1:0]    top_idx;
    logic [PC_W-1:0]    pc_plus1;
    logic [PC_W-1:0]    pc_plus2;

    logic               mem_we;
    logic               push_en;
    logic [3:0]         opcode_c;
    logic               write_c;
    logic               flag_0_c;
    logic               flag_f_c;
    logic               flag_jmp_c;
    logic               flag_rtn_c;

    // pc arithmetic wraps modulo PROG_DEPTH. This also covers depths that are
    // not a power of two.
    function automatic logic [PC_W-1:0] pc_add(input logic [PC_W-1:0] base,
                                               input int unsigned     inc);
        int unsigned sum;
        sum = 32'(base) + inc;
        sum = sum % DEPTH_U;
        return PC_W'(sum);
    endfunction

    assign full_w      = (wr_ptr_q == WP_W'(PROG_DEPTH));
    assign stack_full  = (int'(sp_q) >= STACK_DEPTH);
    assign stack_empty = (sp_q == '0);
    assign top_idx     = sp_q - 1'b1;
    assign pc_plus1    = pc_add(pc_q, 1);
    assign pc_plus2    = pc_add(pc_q, 2);

    always_comb begin
        instr = '0;
        if (int'(pc_q) < PROG_DEPTH) begin
            instr = mem_q[pc_q];
        end
    end

    assign op   = instruction_t'(instr[CMD_W-1 -: 4]);
    assign addr = instr[ADDR_W-1:0];

    // An operand outside the input range reads as 0. IEN=0 forces the
    // operand to 0 as well.
    always_comb begin
        d_bit = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (int'(addr) == i) begin
                d_bit = data_in[i];
            end
        end
        d_bit = d_bit & ien_q;
    end

    assign out_ok = (int'(addr) < NUM_OUT);

    // -----------------------------------------------------------------------
    // Next-state and per-cycle outputs
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        pc_d        = pc_q;
        sp_d        = sp_q;
        rr_d        = rr_q;
        ien_d       = ien_q;
        oen_d       = oen_q;
        data_out_d  = data_out_q;
        stack_ovf_d = stack_ovf_q;
        stack_unf_d = stack_unf_q;
        mem_we      = 1'b0;
        push_en     = 1'b0;
        opcode_c    = OP_NOP0;
        write_c     = 1'b0;
        flag_0_c    = 1'b0;
        flag_f_c    = 1'b0;
        flag_jmp_c  = 1'b0;
        flag_rtn_c  = 1'b0;

        if (program_write) begin
            // Load mode. Execution is frozen, and any instruction that was
            // about to execute is dropped.
            pc_d = '0;
            sp_d = '0;
            if (!full_w) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end else begin
            opcode_c = op;
            pc_d     = pc_plus1;
            case (op)
                OP_NOP0: flag_0_c = 1'b1;
                OP_LD:   rr_d = d_bit;
                OP_LDC:  rr_d = ~d_bit;
                OP_AND:  rr_d = rr_q & d_bit;
                OP_ANDC: rr_d = rr_q & ~d_bit;
                OP_OR:   rr_d = rr_q | d_bit;
                OP_ORC:  rr_d = rr_q | ~d_bit;
                OP_XNOR: rr_d = ~(rr_q ^ d_bit);
                OP_STO, OP_STOC: begin
                    if (oen_q && out_ok) begin
                        write_c = 1'b1;
                        for (int i = 0; i < NUM_OUT; i++) begin
                            if (int'(addr) == i) begin
                                data_out_d[i] = (op == OP_STO) ? rr_q : ~rr_q;
                            end
                        end
                    end
                end
                // The enables latch the result register. A freshly reset
                // unit can therefore turn them on from program code. If they
                // loaded the IEN-gated operand instead, they could never be
                // set again once IEN was 0.
                OP_IEN:  ien_d = rr_q;
                OP_OEN:  oen_d = rr_q;
                OP_JMP: begin
                    flag_jmp_c = 1'b1;
                    pc_d       = PC_W'(addr);
                    if (stack_full) begin
                        stack_ovf_d = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        sp_d    = sp_q + 1'b1;
                    end
                end
                OP_RTN: begin
                    flag_rtn_c = 1'b1;
                    if (stack_empty) begin
                        stack_unf_d = 1'b1;
                    end else begin
                        pc_d = stack_q[top_idx];
                        sp_d = top_idx;
                    end
                end
                OP_SKZ: begin
                    if (!rr_q) begin
                        pc_d = pc_plus2;
                    end
                end
                OP_NOPF: flag_f_c = 1'b1;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            pc_q        <= '0;
            sp_q        <= '0;
            rr_q        <= 1'b0;
            ien_q       <= 1'b0;
            oen_q       <= 1'b0;
            data_out_q  <= '0;
            stack_ovf_q <= 1'b0;
            stack_unf_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            pc_q        <= pc_d;
            sp_q        <= sp_d;
            rr_q        <= rr_d;
            ien_q       <= ien_d;
            oen_q       <= oen_d;
            data_out_q  <= data_out_d;
            stack_ovf_q <= stack_ovf_d;
            stack_unf_q <= stack_unf_d;
        end
    end

    // Program memory and return-stack storage have no reset, so a program
    // survives a reset. Writes are held off while rst_n is low.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            mem_q[wr_ptr_q[PC_W-1:0]] <= program_cmd;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en && rst_n) begin
            stack_q[sp_q] <= pc_plus1;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. While reset is held, the decode is forced idle.
    // -----------------------------------------------------------------------
    assign data_out  = data_out_q;
    assign pc        = pc_q;
    assign rr        = rr_q;
    assign prog_full = full_w;
    assign stack_ovf = stack_ovf_q;
    assign stack_unf = stack_unf_q;
    assign opcode    = rst_n ? opcode_c : OP_NOP0;
    assign write     = rst_n & write_c;
    assign flag_0    = rst_n & flag_0_c;
    assign flag_f    = rst_n & flag_f_c;
    assign flag_jmp  = rst_n & flag_jmp_c;
    assign flag_rtn  = rst_n & flag_rtn_c;

endmodule

// File: tb/tb_mc14500b_icu_param.sv
// ---------------------------------------------------------------------------
// tb_mc14500b_icu_param
//
// Testbench for mc14500b_icu_param. The DUT is built with PROG_DEPTH=32 and
// STACK_DEPTH=2 so that wrap-around and stack-limit cases are reached in a
// few cycles. A behavioural model (instruction list, integer pc, queue
// stack) predicts every output on every cycle. Directed scenarios add
// explicit checks against hand-derived constants.
// ---------------------------------------------------------------------------
module tb_mc14500b_icu_param;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 32;
    localparam int NIN    = 8;
    localparam int NOUT   = 8;
    localparam int SDEPTH = 2;
    localparam int CMD_W  = 12;
    localparam int PC_W   = 5;
    localparam int W      = 14;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             program_write = 1'b0;
    logic [CMD_W-1:0] program_cmd = '0;
    logic [NIN-1:0]   data_in = '0;
    logic [NOUT-1:0]  data_out;
    logic [3:0]       opcode;
    logic [PC_W-1:0]  pc;
    logic             rr;
    logic             write;
    logic             flag_0;
    logic             flag_f;
    logic             flag_jmp;
    logic             flag_rtn;
    logic             prog_full;
    logic             stack_ovf;
    logic             stack_unf;

    always #5 clk = ~clk;

    mc14500b_icu_param #(
        .ADDR_W      (ADDR_W),
        .PROG_DEPTH  (DEPTH),
        .NUM_IN      (NIN),
        .NUM_OUT     (NOUT),
        .STACK_DEPTH (SDEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .program_write (program_write),
        .program_cmd   (program_cmd),
        .data_in       (data_in),
        .data_out      (data_out),
        .opcode        (opcode),
        .pc            (pc),
        .rr            (rr),
        .write         (write),
        .flag_0        (flag_0),
        .flag_f        (flag_f),
        .flag_jmp      (flag_jmp),
        .flag_rtn      (flag_rtn),
        .prog_full     (prog_full),
        .stack_ovf     (stack_ovf),
        .stack_unf     (stack_unf)
    );

    // ---------------- reference model state ----------------
    logic [CMD_W-1:0] m_mem [DEPTH];
    int               m_pc;
    int               m_wr;
    bit               m_rr;
    bit               m_ien;
    bit               m_oen;
    bit               m_ovf;
    bit               m_unf;
    logic [NOUT-1:0]  m_dout;
    int               m_stack[$];

    // ---------------- scoreboard ----------------
    logic [W-1:0]     exp_q[$];
    logic [CMD_W-1:0] prog_q[$];
    logic [NIN-1:0]   din_q[$];
    int               n_checks = 0;
    int               n_fail = 0;
    int               cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic m_reset();
        m_pc   = 0;
        m_wr   = 0;
        m_rr   = 1'b0;
        m_ien  = 1'b0;
        m_oen  = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_dout = '0;
        m_stack.delete();
    endtask

    function automatic logic [CMD_W-1:0] rand_word();
        int unsigned o;
        int unsigned a;
        logic [3:0]  o4;
        logic [7:0]  a8;
        o  = $urandom_range(0, 15);
        a  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 9);
        o4 = o[3:0];
        a8 = a[7:0];
        return {o4, a8};
    endfunction

    // ---------------- driver: one clock of lockstep checking ----------------
    // Outputs are compared on the falling edge. The model then advances by
    // one instruction, and the task returns 1ns after the rising edge.
    task automatic tick();
        logic [CMD_W-1:0] w;
        int               op;
        int               a;
        bit               d;
        bit               wr_en;
        int               nxt;
        @(negedge clk);
        cyc++;
        chk("pc", pc, m_pc);
        chk("rr", rr, m_rr);
        chk("data_out", data_out, m_dout);
        chk("prog_full", prog_full, (m_wr == DEPTH));
        chk("stack_ovf", stack_ovf, m_ovf);
        chk("stack_unf", stack_unf, m_unf);
        if (program_write) begin
            chk("load_opcode", opcode, 0);
            chk("load_flags", {write, flag_0, flag_f, flag_jmp, flag_rtn}, 0);
            if (m_wr < DEPTH) begin
                m_mem[m_wr] = program_cmd;
                m_wr++;
            end
            m_pc = 0;
            m_stack.delete();
        end else begin
            w     = m_mem[m_pc];
            op    = int'(w[11:8]);
            a     = int'(w[7:0]);
            d     = (a < NIN) ? (m_ien && data_in[a]) : 1'b0;
            wr_en = (op == 8 || op == 9) && m_oen && (a < NOUT);
            chk("opcode", opcode, op);
            chk("flag_0", flag_0, (op == 0));
            chk("flag_f", flag_f, (op == 15));
            chk("flag_jmp", flag_jmp, (op == 12));
            chk("flag_rtn", flag_rtn, (op == 13));
            chk("write", write, wr_en);
            nxt = (m_pc + 1) % DEPTH;
            case (op)
                1:  m_rr = d;
                2:  m_rr = !d;
                3:  m_rr = m_rr && d;
                4:  m_rr = m_rr && !d;
                5:  m_rr = m_rr || d;
                6:  m_rr = m_rr || !d;
                7:  m_rr = (m_rr == d);
                8:  if (wr_en) m_dout[a] = m_rr;
                9:  if (wr_en) m_dout[a] = !m_rr;
                10: m_ien = m_rr;
                11: m_oen = m_rr;
                12: begin
                    if (m_stack.size() < SDEPTH) m_stack.push_back((m_pc + 1) % DEPTH);
                    else m_ovf = 1'b1;
                    nxt = a % DEPTH;
                end
                13: begin
                    if (m_stack.size() > 0) nxt = m_stack.pop_back();
                    else m_unf = 1'b1;
                end
                14: if (!m_rr) nxt = (m_pc + 2) % DEPTH;
                default: ;
            endcase
            m_pc = nxt;
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset. rst_n falls between clock edges and the cleared
    // outputs are checked before the next clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_pc", pc, 0);
        chk("rst_rr", rr, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_flags", {write, flag_0, flag_f, flag_jmp, flag_rtn}, 0);
        chk("rst_status", {prog_full, stack_ovf, stack_unf}, 0);
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic load_prog();
        program_write = 1'b1;
        foreach (prog_q[i]) begin
            program_cmd = prog_q[i];
            tick();
        end
        program_write = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_rand(input int n);
        for (int i = 0; i < n; i++) begin
            data_in       = NIN'($urandom);
            program_write = ($urandom_range(0, 24) == 0);
            tick();
        end
        program_write = 1'b0;
    endtask

    task automatic blank_prog();
        prog_q.delete();
        for (int i = 0; i < DEPTH; i++) prog_q.push_back(12'h000);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [CMD_W-1:0] w0;
        logic [W-1:0]     snap;

        // Power-on reset state
        m_reset();
        @(posedge clk);
        #1;
        chk("por_pc", pc, 0);
        chk("por_out", {rr, data_out}, 0);
        chk("por_opcode", opcode, 0);
        chk("por_status", {prog_full, stack_ovf, stack_unf}, 0);
        rst_n = 1'b1;

        // Fill the whole memory plus 3 extra words that must be ignored
        w0 = rand_word();
        program_write = 1'b1;
        for (int i = 0; i < DEPTH + 3; i++) begin
            program_cmd = (i == 0) ? w0 : rand_word();
            tick();
            if (i == DEPTH - 2) chk("prog_full_early", prog_full, 0);
            if (i == DEPTH - 1) chk("prog_full_set", prog_full, 1);
        end
        program_write = 1'b0;
        #1;
        chk("mem0_kept", opcode, w0[11:8]);
        chk("prog_full_hold", prog_full, 1);

        // Random program, random inputs, occasional load-mode interruptions
        run_rand(400);

        // Example program from the datasheet-style walkthrough
        do_reset();
        prog_q = '{12'h6FF, 12'hBFF, 12'hAFF, 12'h800, 12'h801, 12'h200,
                   12'h401, 12'h800, 12'h801, 12'h802, 12'hC00};
        load_prog();
        do_reset();
        data_in = 8'h02;
        run(5);
        chk("ex_dout_lo_11", data_out[1:0], 2'b11);
        run(5);
        chk("ex_dout_lo_000", data_out[2:0], 3'b000);
        chk("ex_op_jmp", opcode, 4'hC);
        chk("ex_flag_jmp", flag_jmp, 1);
        tick();
        chk("ex_pc_wrap0", pc, 0);

        // Nested JMPs with a 2-deep stack, then an RTN chain
        do_reset();
        blank_prog();
        prog_q[0]  = 12'hC24;  // target truncated to 5 bits -> 4
        prog_q[1]  = 12'hD00;
        prog_q[2]  = 12'hF00;
        prog_q[4]  = 12'hC08;
        prog_q[5]  = 12'hD00;
        prog_q[8]  = 12'hC0C;
        prog_q[12] = 12'hD00;
        load_prog();
        tick();
        chk("stk_jmp_trunc", pc, 4);
        tick();
        chk("stk_pc8", pc, 8);
        chk("stk_no_ovf_yet", stack_ovf, 0);
        tick();
        chk("stk_ovf", stack_ovf, 1);
        chk("stk_pc12", pc, 12);
        tick();
        chk("stk_ret2", pc, 5);
        tick();
        chk("stk_ret1", pc, 1);
        chk("stk_no_unf_yet", stack_unf, 0);
        tick();
        chk("stk_unf", stack_unf, 1);
        chk("stk_unf_pc", pc, 2);
        run(2);

        // SKZ, including the wrap from the last address
        do_reset();
        blank_prog();
        prog_q[5]  = 12'hE00;
        prog_q[6]  = 12'hC0A;
        prog_q[7]  = 12'h6FF;
        prog_q[8]  = 12'hC05;
        prog_q[10] = 12'h1FF;
        prog_q[11] = 12'hC1F;
        prog_q[31] = 12'hE00;
        load_prog();
        run(6);
        chk("skz_taken", pc, 7);
        run(3);
        chk("skz_not_taken", pc, 6);
        run(4);
        chk("skz_wrap", pc, 1);

        // Store gating by OEN and by output range
        do_reset();
        blank_prog();
        prog_q[0] = 12'h6FF;
        prog_q[1] = 12'h800;
        prog_q[2] = 12'hBFF;
        prog_q[3] = 12'h808;
        prog_q[4] = 12'h800;
        load_prog();
        tick();
        chk("sto_oen0_write", write, 0);
        tick();
        chk("sto_oen0_dout", data_out, 0);
        tick();
        chk("sto_range_write", write, 0);
        tick();
        chk("sto_range_dout", data_out, 0);
        chk("sto_ok_write", write, 1);
        tick();
        chk("sto_ok_dout", data_out, 8'h01);

        // Asynchronous reset mid-run: the rerun must repeat the first run
        do_reset();
        prog_q.delete();
        for (int i = 0; i < DEPTH; i++) prog_q.push_back(rand_word());
        load_prog();
        do_reset();
        din_q.delete();
        for (int i = 0; i < 40; i++) din_q.push_back(NIN'($urandom));
        for (int i = 0; i < 40; i++) begin
            data_in = din_q[i];
            tick();
            snap = {m_rr, PC_W'(m_pc), m_dout};
            exp_q.push_back(snap);
        end
        #2;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            data_in = din_q[i];
            tick();
            chk("rerun_trace", {rr, pc, data_out}, exp_q.pop_front());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
